// File: rtl/dmem_mmio_bridge_pkg.sv
// Address map, STATUS layout and region decoder for the data-side memory bridge.
// The decoder works on 16-bit byte addresses and ignores the low two bits.
package dmem_map_pkg;

    localparam logic [15:0] MMIO_BASE  = 16'hF000;
    localparam logic [15:0] OFF_TXDATA = 16'h0000;
    localparam logic [15:0] OFF_STATUS = 16'h0004;
    localparam logic [15:0] OFF_CYCLE  = 16'h0008;
    localparam logic [15:0] OFF_TOHOST = 16'h000C;

    localparam int STAT_FULL   = 0;
    localparam int STAT_EMPTY  = 1;
    localparam int STAT_OVF    = 2;
    localparam int STAT_CNT_LO = 4;

    typedef enum logic [2:0] {
        REG_RAM,
        REG_TXDATA,
        REG_STATUS,
        REG_CYCLE,
        REG_TOHOST,
        REG_NONE
    } region_t;

    function automatic region_t decode_region(input logic [15:0] addr);
        logic [15:0] word_addr;
        region_t     r;
        word_addr = addr & ~16'h0003;
        if (addr < MMIO_BASE)                        r = REG_RAM;
        else if (word_addr == MMIO_BASE + OFF_TXDATA) r = REG_TXDATA;
        else if (word_addr == MMIO_BASE + OFF_STATUS) r = REG_STATUS;
        else if (word_addr == MMIO_BASE + OFF_CYCLE)  r = REG_CYCLE;
        else if (word_addr == MMIO_BASE + OFF_TOHOST) r = REG_TOHOST;
        else                                          r = REG_NONE;
        return r;
    endfunction

endpackage

// File: rtl/dmem_mmio_bridge_if.sv
// Core data port plus the TX byte stream, bundled for the memory bridge.
interface dmem_mmio_bridge_if #(
    parameter int WIDTH = 32,
    parameter int DADDR = 16
);
    logic [DADDR-1:0] dmem_addr;
    logic [WIDTH-1:0] dmem_wdata;
    logic [3:0]       dmem_wr_en;
    logic [WIDTH-1:0] dmem_rdata;
    logic [7:0]       tx_data;
    logic             tx_valid;
    logic             tx_ready;

    modport master (
        output dmem_addr, dmem_wdata, dmem_wr_en, tx_ready,
        input  dmem_rdata, tx_data, tx_valid
    );

    modport slave (
        input  dmem_addr, dmem_wdata, dmem_wr_en, tx_ready,
        output dmem_rdata, tx_data, tx_valid
    );
endinterface

// File: rtl/dmem_mmio_bridge_sync_fifo.sv
// Single-clock FIFO; pushes when full are dropped unless a pop frees the slot in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    output logic                     full,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             do_pop;
    logic             do_push;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/dmem_mmio_bridge.sv
// Data-side memory bridge: byte-enabled word RAM plus an MMIO page with
// TX FIFO, cycle counter, STATUS and a sticky TOHOST halt register.
module dmem_mmio_bridge
    import dmem_map_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int DADDR     = 16,
    parameter int RAM_WORDS = 1024,
    parameter int TX_DEPTH  = 8
) (
    input  logic                clk,
    input  logic                reset,
    dmem_mmio_bridge_if.slave   bus,
    output logic                halt,
    output logic [WIDTH-1:0]    halt_code
);
    localparam int RAM_AW = $clog2(RAM_WORDS);
    localparam int CNT_W  = $clog2(TX_DEPTH) + 1;

    region_t           region;
    logic [RAM_AW-1:0] ram_idx;
    logic [WIDTH-1:0]  ram [RAM_WORDS];
    logic [WIDTH-1:0]  cycle_cnt;
    logic              overflow;
    logic              push;
    logic              pop;
    logic              full;
    logic              empty;
    logic              ovf_set;
    logic              ovf_clr;
    logic [CNT_W-1:0]  count;
    logic [3:0]        count_sat;
    logic [WIDTH-1:0]  status_word;

    assign region  = decode_region(16'(bus.dmem_addr));
    assign ram_idx = bus.dmem_addr[RAM_AW+1:2];

    assign push    = (region == REG_TXDATA) & bus.dmem_wr_en[0];
    assign pop     = bus.tx_valid & bus.tx_ready;
    assign ovf_set = push & full & ~pop;
    assign ovf_clr = (region == REG_STATUS) & bus.dmem_wr_en[0] & bus.dmem_wdata[STAT_OVF];

    sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .din   (bus.dmem_wdata[7:0]),
        .full  (full),
        .pop   (pop),
        .dout  (bus.tx_data),
        .empty (empty),
        .count (count)
    );

    assign bus.tx_valid = ~empty;

    always_ff @(posedge clk) begin
        if (region == REG_RAM) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.dmem_wr_en[i]) ram[ram_idx][8*i +: 8] <= bus.dmem_wdata[8*i +: 8];
            end
        end
    end

    // Overflow set takes priority over a software clear in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_cnt <= '0;
            overflow  <= 1'b0;
            halt      <= 1'b0;
            halt_code <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 1'b1;
            if (ovf_set)      overflow <= 1'b1;
            else if (ovf_clr) overflow <= 1'b0;
            if ((region == REG_TOHOST) && (|bus.dmem_wr_en) && (bus.dmem_wdata != '0) && !halt) begin
                halt      <= 1'b1;
                halt_code <= bus.dmem_wdata;
            end
        end
    end

    assign count_sat = (int'(count) > 15) ? 4'hF : 4'(count);

    always_comb begin
        status_word                      = '0;
        status_word[STAT_FULL]           = full;
        status_word[STAT_EMPTY]          = empty;
        status_word[STAT_OVF]            = overflow;
        status_word[STAT_CNT_LO +: 4]    = count_sat;
    end

    always_comb begin
        bus.dmem_rdata = '0;
        case (region)
            REG_RAM:    bus.dmem_rdata = ram[ram_idx];
            REG_STATUS: bus.dmem_rdata = status_word;
            REG_CYCLE:  bus.dmem_rdata = cycle_cnt;
            REG_TOHOST: bus.dmem_rdata = halt_code;
            default:    bus.dmem_rdata = '0;
        endcase
    end
endmodule

// File: tb/tb_dmem_mmio_bridge.sv
// Directed testbench for dmem_mmio_bridge: RAM lanes, TX FIFO, STATUS, CYCLE and TOHOST.
module tb_dmem_mmio_bridge;

    localparam logic [15:0] A_TXDATA = 16'hF000;
    localparam logic [15:0] A_STATUS = 16'hF004;
    localparam logic [15:0] A_CYCLE  = 16'hF008;
    localparam logic [15:0] A_TOHOST = 16'hF00C;
    localparam logic [15:0] A_NONE   = 16'hF020;

    logic        clk;
    logic        reset;
    logic        halt;
    logic [31:0] halt_code;
    int          compared;
    int          mismatched;
    logic [7:0]  drain_exp [8];

    dmem_mmio_bridge_if bus ();

    dmem_mmio_bridge dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .halt      (halt),
        .halt_code (halt_code)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, want finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", tag, observed, expected);
        end
    endtask

    // One write occupies exactly one rising edge; called right after a falling edge.
    task automatic applyStimulus(input logic [15:0] addr, input logic [31:0] wdata, input logic [3:0] wr_en);
        bus.dmem_addr  = addr;
        bus.dmem_wdata = wdata;
        bus.dmem_wr_en = wr_en;
        @(negedge clk);
        bus.dmem_wr_en = 4'b0000;
    endtask

    task automatic checkRead(input string tag, input logic [15:0] addr, input logic [31:0] expected);
        bus.dmem_addr  = addr;
        bus.dmem_wr_en = 4'b0000;
        #1;
        checkOutput(tag, bus.dmem_rdata, expected);
    endtask

    initial begin
        compared       = 0;
        mismatched     = 0;
        reset          = 1'b1;
        bus.dmem_addr  = '0;
        bus.dmem_wdata = '0;
        bus.dmem_wr_en = 4'b0000;
        bus.tx_ready   = 1'b0;
        repeat (2) @(negedge clk);

        $display("[TB] reset state");
        checkOutput("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
        checkOutput("rst_tx_data", 32'(bus.tx_data), 32'd0);
        checkOutput("rst_halt", 32'(halt), 32'd0);
        checkOutput("rst_halt_code", halt_code, 32'd0);
        checkRead("rst_status", A_STATUS, 32'h0000_0002);
        checkRead("rst_cycle", A_CYCLE, 32'd0);

        $display("[TB] cycle counter");
        @(negedge clk);
        reset = 1'b0;
        repeat (100) @(negedge clk);
        checkRead("cycle_100", A_CYCLE, 32'd100);
        @(negedge clk);
        force dut.cycle_cnt = 32'hFFFF_FFFF;
        checkRead("cycle_forced", A_CYCLE, 32'hFFFF_FFFF);
        #4;
        release dut.cycle_cnt;
        @(negedge clk);
        checkRead("cycle_wrap", A_CYCLE, 32'd0);

        $display("[TB] RAM byte lanes");
        applyStimulus(16'h0010, 32'hAABB_CCDD, 4'b1111);
        applyStimulus(16'h0010, 32'h0000_00EE, 4'b0001);
        checkRead("ram_lane0", 16'h0010, 32'hAABB_CCEE);
        checkRead("ram_alias", 16'h1010, 32'hAABB_CCEE);
        applyStimulus(16'h0014, 32'h1111_1111, 4'b1111);
        bus.dmem_addr  = 16'h0014;
        bus.dmem_wdata = 32'h2222_2222;
        bus.dmem_wr_en = 4'b1010;
        #1;
        checkOutput("ram_same_cycle_old", bus.dmem_rdata, 32'h1111_1111);
        @(negedge clk);
        bus.dmem_wr_en = 4'b0000;
        checkRead("ram_next_cycle_new", 16'h0014, 32'h2211_2211);

        $display("[TB] TX FIFO ordering");
        applyStimulus(A_TXDATA, 32'h0000_0041, 4'b0001);
        applyStimulus(A_TXDATA, 32'h0000_0042, 4'b0001);
        applyStimulus(A_TXDATA, 32'h0000_0043, 4'b0001);
        checkRead("status_cnt3", A_STATUS, 32'h0000_0030);
        checkRead("txdata_reads_zero", A_TXDATA, 32'd0);
        bus.tx_ready = 1'b1;
        #1;
        checkOutput("tx_head_41", 32'(bus.tx_data), 32'h41);
        @(negedge clk);
        #1;
        checkOutput("tx_head_42", 32'(bus.tx_data), 32'h42);
        @(negedge clk);
        #1;
        checkOutput("tx_head_43", 32'(bus.tx_data), 32'h43);
        @(negedge clk);
        checkOutput("tx_drained_valid", 32'(bus.tx_valid), 32'd0);
        checkRead("status_empty", A_STATUS, 32'h0000_0002);
        applyStimulus(A_TXDATA, 32'h0000_0055, 4'b0001);
        checkOutput("push_pop_empty_valid", 32'(bus.tx_valid), 32'd1);
        checkOutput("push_pop_empty_data", 32'(bus.tx_data), 32'h55);
        @(negedge clk);
        bus.tx_ready = 1'b0;
        checkOutput("push_pop_empty_drained", 32'(bus.tx_valid), 32'd0);

        $display("[TB] TX FIFO overflow");
        for (int i = 0; i < 9; i++) applyStimulus(A_TXDATA, 32'h60 + 32'(i), 4'b0001);
        checkRead("status_full_ovf", A_STATUS, 32'h0000_0085);
        applyStimulus(A_STATUS, 32'h0000_0003, 4'b0001);
        checkRead("status_clr_ignored", A_STATUS, 32'h0000_0085);
        applyStimulus(A_STATUS, 32'h0000_0004, 4'b0001);
        checkRead("status_ovf_cleared", A_STATUS, 32'h0000_0081);
        bus.tx_ready = 1'b1;
        applyStimulus(A_TXDATA, 32'h0000_0070, 4'b0001);
        bus.tx_ready = 1'b0;
        checkRead("status_full_pushpop", A_STATUS, 32'h0000_0081);
        drain_exp = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h66, 8'h67, 8'h70};
        bus.tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            checkOutput($sformatf("drain_%0d", i), 32'(bus.tx_data), 32'(drain_exp[i]));
            @(negedge clk);
        end
        bus.tx_ready = 1'b0;
        checkOutput("drain_done_valid", 32'(bus.tx_valid), 32'd0);

        $display("[TB] TOHOST");
        applyStimulus(A_TOHOST, 32'h0000_0000, 4'b1111);
        checkOutput("tohost_zero_halt", 32'(halt), 32'd0);
        applyStimulus(A_TOHOST, 32'h0000_0001, 4'b0010);
        checkOutput("tohost_halt", 32'(halt), 32'd1);
        checkOutput("tohost_code", halt_code, 32'h1);
        applyStimulus(A_TOHOST, 32'h0000_0005, 4'b1111);
        checkOutput("tohost_sticky_code", halt_code, 32'h1);
        checkRead("tohost_read", A_TOHOST, 32'h1);

        $display("[TB] reset mid-transfer and unmapped page");
        for (int i = 0; i < 4; i++) applyStimulus(A_TXDATA, 32'h80 + 32'(i), 4'b0001);
        checkOutput("pre_reset_valid", 32'(bus.tx_valid), 32'd1);
        reset        = 1'b1;
        bus.tx_ready = 1'b1;
        @(negedge clk);
        reset        = 1'b0;
        bus.tx_ready = 1'b0;
        checkOutput("post_reset_valid", 32'(bus.tx_valid), 32'd0);
        checkOutput("post_reset_halt", 32'(halt), 32'd0);
        checkOutput("post_reset_code", halt_code, 32'd0);
        applyStimulus(16'h0020, 32'h1357_2468, 4'b1111);
        checkRead("none_read", A_NONE, 32'd0);
        applyStimulus(A_NONE, 32'hFFFF_FFFF, 4'b1111);
        checkRead("none_ram_alias", 16'h0020, 32'h1357_2468);
        checkRead("none_status", A_STATUS, 32'h0000_0002);
        checkRead("none_tohost", A_TOHOST, 32'd0);
        checkRead("ram_survives_reset", 16'h0010, 32'hAABB_CCEE);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
